// File: rtl/imm_extend_pipe.sv
// ============================================================================
// Module   : imm_extend_pipe
// Purpose  : Pipelined immediate extender (sign/zero/upper/branch) with
//            valid, stall and flush control over STAGES register stages.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_extend_pipe #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2,
  parameter int STAGES   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_imm
);

  localparam logic [1:0] C_MODE_SIGN   = 2'b00;
  localparam logic [1:0] C_MODE_ZERO   = 2'b01;
  localparam logic [1:0] C_MODE_UPPER  = 2'b10;
  localparam logic [1:0] C_MODE_BRANCH = 2'b11;

  generate
    if ((OUT_W <= IN_W + BR_SHIFT) || (STAGES < 1) || (STAGES > 4)) begin : g_param_check
      $error("imm_extend_pipe: illegal parameters (need OUT_W > IN_W+BR_SHIFT, STAGES in 1..4)");
    end
  endgenerate

  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_upper;
  logic [OUT_W-1:0] w_branch;
  logic [OUT_W-1:0] w_ext;

  assign w_sext   = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
  assign w_zext   = {{(OUT_W-IN_W){1'b0}}, in_imm};
  assign w_upper  = {in_imm, {(OUT_W-IN_W){1'b0}}};
  assign w_branch = w_sext << BR_SHIFT;

  always_comb begin
    w_ext = w_sext;
    case (in_mode)
      C_MODE_SIGN:   w_ext = w_sext;
      C_MODE_ZERO:   w_ext = w_zext;
      C_MODE_UPPER:  w_ext = w_upper;
      C_MODE_BRANCH: w_ext = w_branch;
      default:       w_ext = w_sext;
    endcase
  end

  logic [STAGES-1:0] r_valid;
  logic [OUT_W-1:0]  r_data [STAGES];

  // Invalid slots always carry zero data so out_imm is 0 whenever out_valid is 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int k = 0; k < STAGES; k++) r_data[k] <= '0;
    end else if (flush) begin
      r_valid <= '0;
      for (int k = 0; k < STAGES; k++) r_data[k] <= '0;
    end else if (!stall) begin
      r_valid[0] <= in_valid;
      r_data[0]  <= in_valid ? w_ext : '0;
      for (int k = 1; k < STAGES; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_data[k]  <= r_data[k-1];
      end
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign out_imm   = r_data[STAGES-1];

endmodule

`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
// ============================================================================
// Module   : tb_imm_extend_pipe
// Purpose  : Self-checking bench for imm_extend_pipe at STAGES = 1, 2 and 3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_extend_pipe;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;

  typedef struct packed {
    logic             v;
    logic [OUT_W-1:0] d;
  } slot_t;

  typedef struct {
    logic [1:0]       mode;
    logic [IN_W-1:0]  imm;
    logic [OUT_W-1:0] exp;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic             stall;
  logic             flush;
  logic             ov [3];
  logic [OUT_W-1:0] oi [3];

  int checks = 0;
  int errors = 0;

  // History of accepted entries; a design with S stages shows the S-th newest.
  slot_t hist[$];
  logic [OUT_W-1:0] obs[$];

  always #5 clk = ~clk;

  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .BR_SHIFT(2), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_imm(in_imm), .in_mode(in_mode),
    .stall(stall), .flush(flush), .out_valid(ov[0]), .out_imm(oi[0]));
  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .BR_SHIFT(2), .STAGES(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_imm(in_imm), .in_mode(in_mode),
    .stall(stall), .flush(flush), .out_valid(ov[1]), .out_imm(oi[1]));
  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .BR_SHIFT(2), .STAGES(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_imm(in_imm), .in_mode(in_mode),
    .stall(stall), .flush(flush), .out_valid(ov[2]), .out_imm(oi[2]));

  function automatic logic [OUT_W-1:0] ref_ext(input logic [1:0] m, input logic [IN_W-1:0] imm);
    longint s;
    longint u;
    s = longint'($signed(imm));
    u = longint'(imm);
    case (m)
      2'd0:    return OUT_W'(s);
      2'd1:    return OUT_W'(u);
      2'd2:    return OUT_W'(u * (longint'(1) << (OUT_W - IN_W)));
      default: return OUT_W'(s * 4);
    endcase
  endfunction

  task automatic chk(input string name, input logic [OUT_W:0] act, input logic [OUT_W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got valid=%0b imm=%h, expected valid=%0b imm=%h",
               name, act[OUT_W], act[OUT_W-1:0], exp[OUT_W], exp[OUT_W-1:0]);
    end
  endtask

  function automatic slot_t model_out(input int st);
    slot_t z;
    z = '0;
    if (hist.size() >= st) return hist[hist.size() - st];
    return z;
  endfunction

  // One clock edge: advance the model, then compare all three designs.
  task automatic step(input string name);
    slot_t e;
    @(posedge clk);
    if (rst || flush) begin
      hist.delete();
    end else if (!stall) begin
      e.v = in_valid;
      e.d = in_valid ? ref_ext(in_mode, in_imm) : '0;
      hist.push_back(e);
      if (hist.size() > 4) void'(hist.pop_front());
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      e = model_out(i + 1);
      chk($sformatf("%s_s%0d", name, i + 1), {ov[i], oi[i]}, {e.v, e.d});
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [IN_W-1:0] imm,
                       input logic s, input logic f);
    in_valid = v;
    in_mode  = m;
    in_imm   = imm;
    stall    = s;
    flush    = f;
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{2'b00, 16'h8001, 32'hFFFF8001};
    vecs[1] = '{2'b01, 16'h8001, 32'h00008001};
    vecs[2] = '{2'b10, 16'h1234, 32'h12340000};
    vecs[3] = '{2'b11, 16'hFFFF, 32'hFFFFFFFC};
    vecs[4] = '{2'b11, 16'h7FFF, 32'h0001FFFC};
    vecs[5] = '{2'b00, 16'h7FFF, 32'h00007FFF};
    vecs[6] = '{2'b10, 16'hFFFF, 32'hFFFF0000};
    vecs[7] = '{2'b11, 16'h8000, 32'hFFFE0000};

    rst = 1'b1;
    drive(1'b0, 2'b00, '0, 1'b0, 1'b0);
    #1;
    chk("reset_s1", {ov[0], oi[0]}, '0);
    chk("reset_s3", {ov[2], oi[2]}, '0);
    step("reset_hold");
    step("reset_hold");
    rst = 1'b0;

    // Extension modes at one stage: result visible after a single edge.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].mode, vecs[i].imm, 1'b0, 1'b0);
      step("vec");
      chk($sformatf("vec%0d", i), {ov[0], oi[0]}, {1'b1, vecs[i].exp});
    end
    drive(1'b0, 2'b00, '0, 1'b0, 1'b0);
    step("bubble");
    chk("bubble_s1", {ov[0], oi[0]}, '0);

    // Stall in the middle of a stream: order kept, C delayed by the stall.
    drive(1'b0, 2'b00, '0, 1'b0, 1'b1);
    step("clr");
    obs.delete();
    drive(1'b1, 2'b01, 16'h00AA, 1'b0, 1'b0); step("sA");
    if (ov[2]) obs.push_back(oi[2]);
    drive(1'b1, 2'b10, 16'h00BB, 1'b0, 1'b0); step("sB");
    if (ov[2]) obs.push_back(oi[2]);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b11, 16'h0003, (i < 2), 1'b0);
      step("sC");
      if (ov[2]) obs.push_back(oi[2]);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 2'b00, '0, 1'b0, 1'b0);
      step("sD");
      if (ov[2]) obs.push_back(oi[2]);
    end
    chk("stall_latC", {ov[2], oi[2]}, {1'b1, 32'h0000000C});
    chk("stall_count", {1'b0, 32'(obs.size())}, {1'b0, 32'd3});
    if (obs.size() == 3) begin
      chk("stall_A", {1'b1, obs[0]}, {1'b1, 32'h000000AA});
      chk("stall_B", {1'b1, obs[1]}, {1'b1, 32'h00BB0000});
      chk("stall_C", {1'b1, obs[2]}, {1'b1, 32'h0000000C});
    end

    // Flush beats stall and in_valid on a full pipe.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b00, 16'h8000 + 16'(i), 1'b0, 1'b0);
      step("fill");
    end
    drive(1'b1, 2'b01, 16'h5555, 1'b1, 1'b1);
    step("flush");
    chk("flush_s3", {ov[2], oi[2]}, '0);
    drive(1'b0, 2'b00, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("post_flush");
      chk("flush_drop", {ov[2], oi[2]}, '0);
    end

    // Asynchronous reset mid-cycle on a full pipe.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b00, 16'h1000 + 16'(i), 1'b0, 1'b0);
      step("fill2");
    end
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_s2", {ov[1], oi[1]}, '0);
    chk("async_rst_s1", {ov[0], oi[0]}, '0);
    hist.delete();
    step("rst_hold");
    #1;
    rst = 1'b0;
    drive(1'b1, 2'b10, 16'hABCD, 1'b0, 1'b0);
    step("rel_accept");
    chk("rel_lat1", {ov[1], oi[1]}, '0);
    drive(1'b0, 2'b00, '0, 1'b0, 1'b0);
    step("rel_wait");
    chk("rel_lat2", {ov[1], oi[1]}, {1'b1, 32'hABCD0000});

    // Random traffic against the history model.
    for (int n = 0; n < 10000; n++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom), 16'($urandom),
            $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
